// File: rtl/pkt_cell_seg.sv
// Packet segmenter/padder: splits packets into cells of at most MAX_LEN beats,
// pads short cells to MIN_LEN, and forwards each cell only once fully buffered.
module pkt_cell_seg #(
    parameter int                DATA_W  = 8,
    parameter int                MAX_LEN = 1500,
    parameter int                MIN_LEN = 46,
    parameter logic [DATA_W-1:0] PAD_VAL = '0,
    parameter int                DEPTH   = 2048,
    parameter int                LDEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    input  logic              din_sop,
    input  logic              din_eop,
    output logic              din_rdy,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    input  logic              dout_rdy,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic              dout_pkt_last,
    output logic              dout_pad,
    output logic              err_drop
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int DAW   = $clog2(DEPTH);
    localparam int LAW   = $clog2(LDEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAD} state_t;

    state_t state_q, state_d;

    logic              en_q;
    logic              in_pkt_q, in_pkt_d;
    logic [LEN_W-1:0]  cnt_wr_q, cnt_wr_d;
    logic [DAW:0]      dwp_q, drp_q;
    logic [LAW:0]      lwp_q, lrp_q;
    logic [DATA_W:0]   dmem [DEPTH];
    logic [LEN_W:0]    lmem [LDEPTH];

    logic [LEN_W-1:0]  cur_len_q, cur_len_d;
    logic              cur_last_q, cur_last_d;
    logic [LEN_W-1:0]  pad_cnt_q, pad_cnt_d;
    logic              first_q, first_d;

    logic [DATA_W-1:0] dout_q, dout_d;
    logic              vld_q, vld_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic              last_q, last_d;
    logic              pad_q, pad_d;
    logic              err_q;

    logic dfull, dempty, lfull, lempty;
    logic acc, store, drop, cell_end;
    logic dpop, lpop, adv, long_enough;
    logic [DATA_W:0]   dhead;
    logic [LEN_W:0]    lhead;

    assign dempty = (dwp_q == drp_q);
    assign dfull  = (dwp_q[DAW] != drp_q[DAW]) &&
                    (dwp_q[DAW-1:0] == drp_q[DAW-1:0]);
    assign lempty = (lwp_q == lrp_q);
    assign lfull  = (lwp_q[LAW] != lrp_q[LAW]) &&
                    (lwp_q[LAW-1:0] == lrp_q[LAW-1:0]);

    // en_q keeps din_rdy low until the first edge after reset release
    assign din_rdy  = en_q && !dfull && !lfull;
    assign acc      = din_vld && din_rdy;
    assign store    = acc && (in_pkt_q || din_sop);
    assign drop     = acc && !in_pkt_q && !din_sop;
    assign cell_end = store &&
                      (din_eop || cnt_wr_q == LEN_W'(MAX_LEN - 1));

    always_comb begin
        in_pkt_d = in_pkt_q;
        cnt_wr_d = cnt_wr_q;
        if (store) begin
            in_pkt_d = !din_eop;
            cnt_wr_d = cell_end ? '0 : cnt_wr_q + LEN_W'(1);
        end
    end

    assign dhead       = dmem[drp_q[DAW-1:0]];
    assign lhead       = lmem[lrp_q[LAW-1:0]];
    assign adv         = !vld_q || dout_rdy;
    assign long_enough = cur_len_q >= LEN_W'(MIN_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (!lempty) state_d = S_DATA;
            S_DATA: begin
                if (adv && !dempty && dhead[0]) begin
                    if (!long_enough) state_d = S_PAD;
                    else if (lempty)  state_d = S_IDLE;
                end
            end
            S_PAD: begin
                if (adv && pad_cnt_q == LEN_W'(1))
                    state_d = lempty ? S_IDLE : S_DATA;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dpop       = 1'b0;
        lpop       = 1'b0;
        cur_len_d  = cur_len_q;
        cur_last_d = cur_last_q;
        pad_cnt_d  = pad_cnt_q;
        first_d    = first_q;
        dout_d     = dout_q;
        vld_d      = vld_q;
        sop_d      = sop_q;
        eop_d      = eop_q;
        last_d     = last_q;
        pad_d      = pad_q;
        if (adv) begin
            vld_d  = 1'b0;
            sop_d  = 1'b0;
            eop_d  = 1'b0;
            last_d = 1'b0;
            pad_d  = 1'b0;
        end
        unique case (state_q)
            S_IDLE: begin
                if (!lempty) begin
                    lpop       = 1'b1;
                    cur_len_d  = lhead[LEN_W:1];
                    cur_last_d = lhead[0];
                    first_d    = 1'b1;
                end
            end
            S_DATA: begin
                if (adv && !dempty) begin
                    dpop    = 1'b1;
                    dout_d  = dhead[DATA_W:1];
                    vld_d   = 1'b1;
                    sop_d   = first_q;
                    first_d = 1'b0;
                    eop_d   = dhead[0] && long_enough;
                    last_d  = dhead[0] && long_enough && cur_last_q;
                    if (dhead[0]) begin
                        if (!long_enough) begin
                            pad_cnt_d = LEN_W'(MIN_LEN) - cur_len_q;
                        end else if (!lempty) begin
                            lpop       = 1'b1;
                            cur_len_d  = lhead[LEN_W:1];
                            cur_last_d = lhead[0];
                            first_d    = 1'b1;
                        end
                    end
                end
            end
            S_PAD: begin
                if (adv) begin
                    dout_d    = PAD_VAL;
                    vld_d     = 1'b1;
                    pad_d     = 1'b1;
                    eop_d     = (pad_cnt_q == LEN_W'(1));
                    last_d    = (pad_cnt_q == LEN_W'(1)) && cur_last_q;
                    pad_cnt_d = pad_cnt_q - LEN_W'(1);
                    if (pad_cnt_q == LEN_W'(1) && !lempty) begin
                        lpop       = 1'b1;
                        cur_len_d  = lhead[LEN_W:1];
                        cur_last_d = lhead[0];
                        first_d    = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (store)    dmem[dwp_q[DAW-1:0]] <= {din, cell_end};
        if (cell_end) lmem[lwp_q[LAW-1:0]] <= {cnt_wr_q + LEN_W'(1), din_eop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            in_pkt_q   <= 1'b0;
            cnt_wr_q   <= '0;
            dwp_q      <= '0;
            drp_q      <= '0;
            lwp_q      <= '0;
            lrp_q      <= '0;
            cur_len_q  <= '0;
            cur_last_q <= 1'b0;
            pad_cnt_q  <= '0;
            first_q    <= 1'b0;
            dout_q     <= '0;
            vld_q      <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            last_q     <= 1'b0;
            pad_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            en_q       <= 1'b1;
            in_pkt_q   <= in_pkt_d;
            cnt_wr_q   <= cnt_wr_d;
            if (store)    dwp_q <= dwp_q + 1'b1;
            if (dpop)     drp_q <= drp_q + 1'b1;
            if (cell_end) lwp_q <= lwp_q + 1'b1;
            if (lpop)     lrp_q <= lrp_q + 1'b1;
            cur_len_q  <= cur_len_d;
            cur_last_q <= cur_last_d;
            pad_cnt_q  <= pad_cnt_d;
            first_q    <= first_d;
            dout_q     <= dout_d;
            vld_q      <= vld_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            last_q     <= last_d;
            pad_q      <= pad_d;
            err_q      <= drop;
        end
    end

    assign dout          = dout_q;
    assign dout_vld      = vld_q;
    assign dout_sop      = sop_q;
    assign dout_eop      = eop_q;
    assign dout_pkt_last = last_q;
    assign dout_pad      = pad_q;
    assign err_drop      = err_q;

endmodule

// File: tb/tb_pkt_cell_seg.sv
// Directed bench for pkt_cell_seg: padding, segmentation, boundaries,
// backpressure, overflow, stray-beat drop and mid-cell reset.
module tb_pkt_cell_seg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = '0;
    logic       din_vld = 1'b0;
    logic       din_sop = 1'b0;
    logic       din_eop = 1'b0;
    logic       din_rdy;
    logic [7:0] dout;
    logic       dout_vld;
    logic       dout_rdy = 1'b1;
    logic       dout_sop;
    logic       dout_eop;
    logic       dout_pkt_last;
    logic       dout_pad;
    logic       err_drop;

    int checks = 0;
    int failures = 0;
    int rdy_mode = 1;
    int cyc = 0;
    int stall_err = 0;
    int stall_cnt = 0;

    logic [11:0] got[$];
    int          stamp[$];
    logic [11:0] exp_q[$];

    pkt_cell_seg dut (
        .clk(clk), .rst_n(rst_n),
        .din(din), .din_vld(din_vld), .din_sop(din_sop),
        .din_eop(din_eop), .din_rdy(din_rdy),
        .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
        .dout_sop(dout_sop), .dout_eop(dout_eop),
        .dout_pkt_last(dout_pkt_last), .dout_pad(dout_pad),
        .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 0)      dout_rdy = 1'b0;
        else if (rdy_mode == 1) dout_rdy = 1'b1;
        else                    dout_rdy = 1'($urandom_range(0, 1));
    end

    // Collects accepted beats and checks hold-stability while stalled
    initial begin
        logic        stalled;
        logic [11:0] held;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled && {dout_vld, dout_pad, dout_pkt_last, dout_eop,
                                dout_sop, dout} !== {1'b1, held})
                    stall_err++;
                if (dout_vld && dout_rdy) begin
                    got.push_back({dout_pad, dout_pkt_last, dout_eop,
                                   dout_sop, dout});
                    stamp.push_back(cyc);
                end
                stalled = dout_vld && !dout_rdy;
                if (stalled) stall_cnt++;
                held = {dout_pad, dout_pkt_last, dout_eop, dout_sop, dout};
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic send_beats(input int n, input logic [7:0] base,
                              input bit sop, input bit eop);
        for (int i = 0; i < n; i++) begin
            int t;
            bit done;
            din     = base + 8'(i);
            din_vld = 1'b1;
            din_sop = sop && (i == 0);
            din_eop = eop && (i == n - 1);
            t = 0;
            done = 1'b0;
            while (!done && t < 20000) begin
                @(negedge clk);
                done = din_rdy;
                @(posedge clk);
                #1;
                t++;
            end
            if (!done) begin
                chk("send_rdy", 32'(done), 32'd1);
                break;
            end
        end
        din_vld = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
    endtask

    // Expected cells: MAX_LEN 1500, MIN_LEN 46, PAD_VAL 0
    task automatic expect_pkt(input int len, input logic [7:0] base);
        int  rem;
        int  c;
        int  k;
        bit  fin;
        bit  e;
        rem = len;
        k = 0;
        while (rem > 0) begin
            c = (rem > 1500) ? 1500 : rem;
            fin = (rem == c);
            for (int i = 0; i < c; i++) begin
                e = (i == c - 1) && (c >= 46);
                exp_q.push_back({1'b0, e && fin, e, i == 0, base + 8'(k)});
                k++;
            end
            if (c < 46) begin
                for (int i = 0; i < 46 - c; i++) begin
                    e = (i == 45 - c);
                    exp_q.push_back({1'b1, e && fin, e, 1'b0, 8'h00});
                end
            end
            rem -= c;
        end
    endtask

    task automatic check_out(input int mark, input string tag);
        int t;
        t = 0;
        while (got.size() < mark + exp_q.size() && t < 20000) begin
            @(posedge clk);
            t++;
        end
        repeat (6) @(posedge clk);
        #1;
        chk({tag, "_count"}, 32'(got.size() - mark), 32'(exp_q.size()));
        if (got.size() >= mark + exp_q.size()) begin
            for (int i = 0; i < exp_q.size(); i++)
                chk($sformatf("%s_beat%0d", tag, i), 32'(got[mark + i]),
                    32'(exp_q[i]));
        end
    endtask

    initial begin
        int mark;
        int len;
        logic [7:0] b;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {24'd0, dout, dout_vld, dout_sop, dout_eop, dout_pkt_last,
             dout_pad, err_drop, din_rdy}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_reset", 32'(din_rdy), 32'd1);

        mark = got.size();
        exp_q.delete();
        expect_pkt(10, 8'h01);
        send_beats(10, 8'h01, 1, 1);
        chk("lat_edge_n", 32'(dout_vld), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_edge_n1", 32'(dout_vld), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_edge_n2", {22'd0, dout_vld, dout_sop, dout}, {22'd0, 10'h301});
        check_out(mark, "short10");

        mark = got.size();
        exp_q.delete();
        expect_pkt(3200, 8'h10);
        send_beats(3200, 8'h10, 1, 1);
        check_out(mark, "long3200");
        if (stamp.size() >= mark + 3200) begin
            chk("gap_cell1_2", 32'(stamp[mark + 1500] - stamp[mark + 1499]), 32'd1);
            chk("gap_cell2_3", 32'(stamp[mark + 3000] - stamp[mark + 2999]), 32'd1);
        end

        mark = got.size();
        exp_q.delete();
        expect_pkt(46, 8'h20);
        expect_pkt(1500, 8'h30);
        expect_pkt(1501, 8'h40);
        expect_pkt(1, 8'hA5);
        send_beats(46, 8'h20, 1, 1);
        send_beats(1500, 8'h30, 1, 1);
        send_beats(1501, 8'h40, 1, 1);
        send_beats(1, 8'hA5, 1, 1);
        check_out(mark, "bounds");

        rdy_mode = 2;
        mark = got.size();
        exp_q.delete();
        for (int p = 0; p < 5; p++) begin
            len = $urandom_range(1, 120);
            b = 8'($urandom_range(0, 255));
            expect_pkt(len, b);
            send_beats(len, b, 1, 1);
        end
        check_out(mark, "bp");
        chk("bp_stall_stable", 32'(stall_err), 32'd0);
        chk("bp_stalls_seen", 32'(stall_cnt > 0), 32'd1);

        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        mark = got.size();
        exp_q.delete();
        for (int p = 0; p < 20; p++) expect_pkt(64, 8'(p * 7));
        for (int p = 0; p < 17; p++) send_beats(64, 8'(p * 7), 1, 1);
        @(negedge clk);
        chk("ovf_din_rdy_low", 32'(din_rdy), 32'd0);
        chk("ovf_dout_held", {30'd0, dout_vld, dout_sop}, 32'd3);
        rdy_mode = 1;
        for (int p = 17; p < 20; p++) send_beats(64, 8'(p * 7), 1, 1);
        check_out(mark, "ovf");
        chk("ovf_stall_stable", 32'(stall_err), 32'd0);

        mark = got.size();
        send_beats(1, 8'hEE, 0, 0);
        chk("drop_pulse", 32'(err_drop), 32'd1);
        @(posedge clk);
        #1;
        chk("drop_pulse_end", 32'(err_drop), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("drop_no_output", 32'(got.size() - mark), 32'd0);
        exp_q.delete();
        expect_pkt(3, 8'h60);
        send_beats(3, 8'h60, 1, 1);
        check_out(mark, "after_drop");

        send_beats(30, 8'h70, 1, 1);
        send_beats(10, 8'h90, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("midcell_active", 32'(dout_vld), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midcell_reset_outputs",
            {24'd0, dout, dout_vld, dout_sop, dout_eop, dout_pkt_last,
             dout_pad, err_drop, din_rdy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mark = got.size();
        exp_q.delete();
        expect_pkt(5, 8'hC0);
        send_beats(5, 8'hC0, 1, 1);
        check_out(mark, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pkt_cell_seg.md
# pkt_cell_seg

Parametrised packet segmenter and padder for the byte-stream datapath. It splits each incoming packet into cells of at most `MAX_LEN` beats. Any cell shorter than `MIN_LEN` is padded with `PAD_VAL` beats. Each cell is buffered completely before it is forwarded (store-and-forward per cell), and both sides use valid/ready flow control.

## Interface
- `DATA_W`, 8, beat width.
- `MAX_LEN`, 1500, maximum cell length in beats; a cell closes at `din_eop` or at the `MAX_LEN`-th beat.
- `MIN_LEN`, 46, minimum output cell length in beats; 1 ≤ `MIN_LEN` ≤ `MAX_LEN`.
- `PAD_VAL`, 0, value driven on pad beats.
- `DEPTH`, 2048, data FIFO depth in beats; power of 2; `DEPTH` ≥ `MAX_LEN`.
- `LDEPTH`, 16, length FIFO depth in cells; power of 2.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `din`  in  `DATA_W`  input beat.
- `din_vld`  in  1  input beat valid.
- `din_sop`  in  1  first beat of packet.
- `din_eop`  in  1  last beat of packet.
- `din_rdy`  out  1  block can accept a beat; a beat is accepted when `din_vld && din_rdy`.
- `dout`  out  `DATA_W`  output beat.
- `dout_vld`  out  1  output beat valid.
- `dout_rdy`  in  1  downstream accepts the beat.
- `dout_sop`  out  1  first beat of a cell.
- `dout_eop`  out  1  last beat of a cell, including the last pad beat when the cell is padded.
- `dout_pkt_last`  out  1  asserted with `dout_eop` on the final cell of a packet.
- `dout_pad`  out  1  current beat is padding.
- `err_drop`  out  1  one-cycle pulse when a stray beat is discarded.

## Operation
- **Write side**
  - `in_pkt` is set by an accepted `din_sop` and cleared by an accepted `din_eop`.
  - A beat accepted with `in_pkt==0` and `din_sop==0` is discarded and pulses `err_drop`.
  - `din_sop` received while `in_pkt==1` is treated as ordinary data.
  - A beat carrying `din_sop` and `din_eop` together is a 1-beat packet.
  - Cell counter `cnt_wr` (`LEN_W` = clog2(`MAX_LEN`+1) bits) increments on every stored beat.
  - Cell end = stored beat with (`cnt_wr==MAX_LEN-1` or `din_eop`). On cell end:
    - push {`cnt_wr`+1, `din_eop`} into the length FIFO;
    - clear `cnt_wr`.
  - Data FIFO entry = {beat, cell-last flag}.
- **`din_rdy`** = !reset && data FIFO not full && length FIFO not full. It is registered-status driven, with no combinational path from `din_vld`.
- **Read-side FSM**
  - `IDLE`: when the length FIFO is non-empty, pop the entry into `cur_len` / `cur_last` → `DATA`.
  - `DATA`: emit beats from the data FIFO. On the cell-last beat:
    - if `cur_len` ≥ `MIN_LEN` → `IDLE`, or directly start the next cell if a length entry is available;
    - else load `pad_cnt` = `MIN_LEN`-`cur_len` → `PAD`.
  - `PAD`: emit `PAD_VAL` with `dout_pad=1`. Decrement `pad_cnt` per accepted beat; the beat with `pad_cnt==1` carries `dout_eop` → `IDLE` or the next cell.
- **Output flags**
  - `dout_sop` is set on the first beat of each cell.
  - `dout_eop` is set on the final beat (data or pad).
  - `dout_pkt_last` = `dout_eop` && `cur_last`.
- **Pad arithmetic**: computed in `LEN_W` bits, and only when `cur_len` < `MIN_LEN`, so it never underflows.
- **Output register**: loads when `!dout_vld || dout_rdy`. `dout` and all flags hold stable while `dout_vld && !dout_rdy`.
- **Deadlock freedom**: guaranteed by `DEPTH` ≥ `MAX_LEN`, since a complete cell always fits.

## Timing
- **Reset values**: `dout`=0, `dout_vld`=0, `dout_sop`=0, `dout_eop`=0, `dout_pkt_last`=0, `dout_pad`=0, `err_drop`=0, `din_rdy`=0.
  - Both FIFOs empty, FSM in `IDLE`, `in_pkt`=0, `cnt_wr`=0.
  - Reset mid-packet discards all buffered data; outputs are zero after the asserting edge.
- **Latency**: a cell-last beat accepted at edge N gives `dout_vld`=1 with `dout_sop` after edge N+2, provided the FSM is idle and `dout_rdy`=1.
- **Throughput**: 1 beat/cycle when `dout_rdy`=1. There are 0 idle cycles between the `dout_eop` beat and the next `dout_sop` when the next length entry is already queued.
- **Simultaneous push/pop**: allowed on both FIFOs in the same cycle. Full/empty evaluate correctly, and the FIFOs are never both full and written.
- **`err_drop`**: asserted in the cycle after the discarded beat.

## Test plan
- **Short packet padded**: 10-beat packet 0x01..0x0A, `dout_rdy`=1 → 46 beats total.
  - Beats 1-10 carry the data; beats 11-46 are 0x00 with `dout_pad`=1.
  - `dout_sop` on beat 1; `dout_eop` and `dout_pkt_last` on beat 46.
- **Long packet segmented**: 3200-beat packet → cells of 1500, 1500 and 200 beats with no padding.
  - `dout_eop` on each cell; `dout_pkt_last` only on the 200-beat cell.
  - Zero gaps between cells.
- **Boundary lengths**:
  - 46 beats → 46 out with no pad.
  - 1500 beats → one cell with `pkt_last`.
  - 1501 beats → a 1500-beat cell, then a 46-beat cell with 45 pad beats.
  - A 1-beat sop+eop packet → 46 beats out.
- **Output backpressure**: 5 random packets with `dout_rdy` toggled randomly at 50%.
  - Output stays stable during every stall.
  - The beat sequence is identical to the `dout_rdy`=1 run.
- **Input overflow**: `dout_rdy`=0 while 64-beat packets are streamed.
  - `din_rdy` falls when either FIFO is full; no beats are lost.
  - All packets are output after `dout_rdy`=1.
- **Errors and reset**:
  - Stray beat without sop → `err_drop` pulse, and the beat is never output.
  - `rst_n` asserted mid-cell → every output is 0; after release a new packet is processed cleanly.
